// File: rtl/sum_uart_tx.sv
// Streams the delay-and-sum result RAM off-chip over an 8N1 UART: one sync byte, then every
// sum word in address order, LSB byte first.
module sum_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned NUM_WORDS    = 768,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DATA_W       = 40,
  parameter int unsigned RD_LAT       = 2,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] sum_read_addr,
  output logic              sum_read_en,
  input  logic [DATA_W-1:0] sum_ram_data_out,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NumBytes = (DATA_W + 7) / 8;
  localparam int unsigned ShW      = NumBytes * 8;
  localparam int unsigned BaudW    = $clog2(CLKS_PER_BIT);
  localparam int unsigned ByteW    = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam int unsigned WaitW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {StIdle, StSync, StRd, StWait, StSend, StDone} state_e;

  state_e             state_q, state_d;
  logic [BaudW-1:0]   baud_q, baud_d;
  logic [3:0]         bit_q, bit_d;
  logic [ByteW-1:0]   byte_q, byte_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic [ADDR_W-1:0]  word_q, word_d;
  logic [ShW-1:0]     sh_q, sh_d;

  logic       baud_end, frame_end;
  logic [7:0] cur_byte;

  assign baud_end  = (baud_q == BaudW'(CLKS_PER_BIT - 1));
  assign frame_end = baud_end && (bit_q == 4'd9);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    wait_d  = wait_q;
    word_d  = word_q;
    sh_d    = sh_q;

    // Shared bit timing for the sync frame and data frames.
    if (state_q == StSync || state_q == StSend) begin
      if (baud_end) begin
        baud_d = '0;
        bit_d  = bit_q + 4'd1;
      end else begin
        baud_d = baud_q + BaudW'(1);
      end
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSync;
          baud_d  = '0;
          bit_d   = '0;
          word_d  = '0;
        end
      end
      StSync: begin
        if (frame_end) begin
          bit_d   = '0;
          state_d = StRd;
        end
      end
      StRd: begin
        wait_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        // Last wait cycle coincides with read data becoming valid.
        if (wait_q == WaitW'(RD_LAT - 1)) begin
          sh_d    = ShW'(sum_ram_data_out);
          baud_d  = '0;
          bit_d   = '0;
          byte_d  = '0;
          state_d = StSend;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StSend: begin
        if (frame_end) begin
          sh_d  = sh_q >> 8;
          bit_d = '0;
          if (byte_q == ByteW'(NumBytes - 1)) begin
            if (word_q == ADDR_W'(NUM_WORDS - 1)) begin
              state_d = StDone;
            end else begin
              word_d  = word_q + ADDR_W'(1);
              state_d = StRd;
            end
          end else begin
            byte_d = byte_q + ByteW'(1);
          end
        end
      end
      StDone: begin
        word_d  = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      wait_q  <= '0;
      word_q  <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      wait_q  <= wait_d;
      word_q  <= word_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    cur_byte = (state_q == StSync) ? SYNC_BYTE : sh_q[7:0];
    tx       = 1'b1;
    if (state_q == StSync || state_q == StSend) begin
      if (bit_q == 4'd0) begin
        tx = 1'b0;
      end else if (bit_q <= 4'd8) begin
        tx = cur_byte[3'(bit_q - 4'd1)];
      end
    end
  end

  assign busy          = (state_q == StSync) || (state_q == StRd) ||
                         (state_q == StWait) || (state_q == StSend);
  assign done          = (state_q == StDone);
  assign sum_read_en   = (state_q == StRd);
  assign sum_read_addr = word_q;

endmodule
